// File: rtl/hs_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module  : hs_stream_fifo
// Brief   : First-word fall-through valid/ready stream FIFO with a sticky
//           upstream handshake-protocol monitor.
// Rev     : 1.0
// ============================================================================
module hs_stream_fifo #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_W-1:0]      s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_W-1:0]      m_data,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] level,
    output logic                   almost_full,
    output logic                   err_valid_drop,
    output logic                   err_data_chg
);

    localparam int                 c_ptr_w = $clog2(DEPTH) + 1;
    localparam int                 c_idx_w = c_ptr_w - 1;
    localparam logic [c_ptr_w-1:0] c_depth = c_ptr_w'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_afull = c_ptr_w'(AFULL_LVL);
    localparam logic [c_ptr_w-1:0] c_one   = c_ptr_w'(1);
    localparam logic [c_ptr_w-1:0] c_zero  = '0;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic               r_rdy;
    logic               r_stall;
    logic [DATA_W-1:0]  r_held_data;
    logic               r_err_valid_drop;
    logic               r_err_data_chg;

    logic [c_ptr_w-1:0] w_level;
    logic               w_s_ready;
    logic               w_m_valid;
    logic               w_push;
    logic               w_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign w_s_ready = r_rdy & (w_level != c_depth) & ~flush;
    assign w_m_valid = (w_level != c_zero) & ~flush;
    assign w_push    = s_valid & w_s_ready;
    assign w_pop     = w_m_valid & m_ready;

    assign s_ready        = w_s_ready;
    assign m_valid        = w_m_valid;
    assign m_data         = r_mem[r_rd_ptr[c_idx_w-1:0]];
    assign level          = w_level;
    assign almost_full    = (w_level >= c_afull);
    assign err_valid_drop = r_err_valid_drop;
    assign err_data_chg   = r_err_data_chg;

    // Storage needs no reset: contents are only observable while level != 0.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_idx_w-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= c_zero;
            r_rd_ptr <= c_zero;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
            if (flush) begin
                r_wr_ptr <= c_zero;
                r_rd_ptr <= c_zero;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_one;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_one;
                end
            end
        end
    end

    // Upstream monitor: a stalled beat must stay valid with unchanged payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall          <= 1'b0;
            r_held_data      <= '0;
            r_err_valid_drop <= 1'b0;
            r_err_data_chg   <= 1'b0;
        end else if (flush) begin
            r_stall          <= 1'b0;
            r_err_valid_drop <= 1'b0;
            r_err_data_chg   <= 1'b0;
        end else begin
            if (r_stall && !s_valid) begin
                r_err_valid_drop <= 1'b1;
            end
            if (r_stall && s_valid && (s_data != r_held_data)) begin
                r_err_data_chg <= 1'b1;
            end
            if (s_valid && !w_s_ready) begin
                r_stall     <= 1'b1;
                r_held_data <= s_data;
            end else begin
                r_stall <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hs_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_hs_stream_fifo
// Brief   : Directed and randomized bench for hs_stream_fifo against a queue model.
// Rev     : 1.0
// ============================================================================
module tb_hs_stream_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AFULL = DEPTH - 2;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data  = '0;
    logic          m_ready = 1'b0;
    logic          flush   = 1'b0;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [3:0]    level;
    logic          almost_full;
    logic          err_valid_drop;
    logic          err_data_chg;

    hs_stream_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .flush          (flush),
        .level          (level),
        .almost_full    (almost_full),
        .err_valid_drop (err_valid_drop),
        .err_data_chg   (err_data_chg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: occupancy is the queue, the monitor is a few flags.
    logic [DW-1:0] mq[$];
    bit            md_rdy;
    bit            md_stall;
    bit            md_edrop;
    bit            md_echg;
    logic [DW-1:0] md_held;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        md_rdy   = 1'b0;
        md_stall = 1'b0;
        md_edrop = 1'b0;
        md_echg  = 1'b0;
        md_held  = '0;
    endtask

    // One clock cycle: drive, check outputs at the negedge, advance the model at the posedge.
    task automatic step(input bit sv, input logic [31:0] sd, input bit mr, input bit fl);
        bit exp_sr;
        bit exp_mv;
        bit push;
        bit pop;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        @(negedge clk);
        exp_sr = md_rdy && (mq.size() < DEPTH) && !fl;
        exp_mv = (mq.size() > 0) && !fl;
        check("s_ready",     32'(s_ready),        32'(exp_sr));
        check("m_valid",     32'(m_valid),        32'(exp_mv));
        check("level",       32'(level),          32'(mq.size()));
        check("almost_full", 32'(almost_full),    32'(mq.size() >= AFULL));
        check("err_vdrop",   32'(err_valid_drop), 32'(md_edrop));
        check("err_dchg",    32'(err_data_chg),   32'(md_echg));
        if (exp_mv) begin
            check("m_data", m_data, mq[0]);
        end
        push = sv && exp_sr;
        pop  = exp_mv && mr;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            md_edrop = 1'b0;
            md_echg  = 1'b0;
            md_stall = 1'b0;
        end else begin
            if (md_stall && !sv) md_edrop = 1'b1;
            if (md_stall && sv && (sd != md_held)) md_echg = 1'b1;
            md_stall = sv && !exp_sr;
            if (md_stall) md_held = sd;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(sd);
        end
        md_rdy = 1'b1;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        bit            cv;
        logic [31:0]   cd;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready", 32'(s_ready), 32'h0);
        check("rst_m_valid", 32'(m_valid), 32'h0);
        check("rst_level",   32'(level),   32'h0);
        check("rst_afull",   32'(almost_full), 32'h0);
        check("rst_errs",    32'({err_valid_drop, err_data_chg}), 32'h0);
        rst_n = 1'b1;

        // Fill with 0x11..0x88 while downstream stalls.
        for (int k = 1; k <= DEPTH; k++) step(1'b1, 32'(k * 8'h11), 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // From full: continuous push of 0x99 with continuous pop.
        for (int k = 0; k < DEPTH + 2; k++) step(1'b1, 32'h99, 1'b1, 1'b0);
        drain();

        // Randomized traffic from a protocol-compliant master.
        cv = 1'b0;
        cd = '0;
        for (int k = 0; k < 300; k++) begin
            if (!md_stall) begin
                cv = ($urandom_range(0, 9) < 6);
                cd = $urandom;
            end
            step(cv, cd, ($urandom_range(0, 9) < 5), ($urandom_range(0, 39) == 0));
        end
        drain();

        // Flush at level 5 with both sides requesting.
        for (int k = 0; k < 5; k++) step(1'b1, 32'h50 + 32'(k), 1'b0, 1'b0);
        step(1'b1, 32'h5F, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // Protocol violations while full, then flush clears them.
        for (int k = 0; k < DEPTH; k++) step(1'b1, 32'h60 + 32'(k), 1'b0, 1'b0);
        step(1'b1, 32'hAB, 1'b0, 1'b0);
        step(1'b1, 32'hCD, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // Asynchronous reset at level 4 in the middle of a transfer.
        for (int k = 0; k < 4; k++) step(1'b1, 32'h70 + 32'(k), 1'b0, 1'b0);
        s_valid = 1'b1;
        m_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_s_ready", 32'(s_ready), 32'h0);
        check("arst_m_valid", 32'(m_valid), 32'h0);
        check("arst_level",   32'(level),   32'h0);
        check("arst_afull",   32'(almost_full), 32'h0);
        model_reset();
        #1;
        rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h77, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
